// File: rtl/tcdm_responder.sv
// tcdm_responder: multi-port TCDM slave backed by word-interleaved banks.
// Each bank, plus one pseudo-bank for out-of-range accesses, runs its own
// round-robin arbiter. Grants are combinational, and the response
// (r_valid/r_data) follows the grant by one cycle. Bank contents have no reset.
`timescale 1ns/1ps

module tcdm_responder #(
  parameter int unsigned N_PORTS    = 3,
  parameter int unsigned N_BANKS    = 4,
  parameter int unsigned BANK_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_PORTS-1:0]       tcdm_req,
  output logic [N_PORTS-1:0]       tcdm_gnt,
  input  logic [N_PORTS-1:0][31:0] tcdm_add,
  input  logic [N_PORTS-1:0]       tcdm_wen,
  input  logic [N_PORTS-1:0][3:0]  tcdm_be,
  input  logic [N_PORTS-1:0][31:0] tcdm_data,
  output logic [N_PORTS-1:0][31:0] tcdm_r_data,
  output logic [N_PORTS-1:0]       tcdm_r_valid,
  output logic                     oor_err
);

  localparam int unsigned LOG_NB = $clog2(N_BANKS);
  localparam int unsigned LOG_BW = $clog2(BANK_WORDS);
  localparam int unsigned BSW    = (LOG_NB > 0) ? LOG_NB : 1;
  localparam int unsigned RW     = (LOG_BW > 0) ? LOG_BW : 1;
  localparam int unsigned PW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  // Target index N_BANKS is the out-of-range pseudo-bank.
  localparam int unsigned TW     = $clog2(N_BANKS + 1);
  localparam logic [32:0] MEM_BYTES = 33'(N_BANKS) * 33'(BANK_WORDS) * 33'd4;

  logic [N_PORTS-1:0][31:0]    w_off;
  logic [N_PORTS-1:0]          w_inr;
  logic [N_PORTS-1:0][BSW-1:0] w_bank;
  logic [N_PORTS-1:0][RW-1:0]  w_row;
  logic [N_PORTS-1:0][TW-1:0]  w_tgt;
  logic [N_PORTS-1:0]          w_req;
  logic [N_PORTS-1:0]          w_gnt;

  logic [N_BANKS:0][PW-1:0]    r_ptr;
  logic [N_BANKS:0][PW-1:0]    w_win;
  logic [N_BANKS:0]            w_win_vld;

  logic [N_BANKS-1:0][31:0]    w_bank_q;
  logic [N_PORTS-1:0]          r_valid;
  logic [N_PORTS-1:0]          r_rd_hit;
  logic [N_PORTS-1:0][BSW-1:0] r_rsel;
  logic                        r_oor;

  // Requests are masked during reset, so nothing is granted or written then.
  assign w_req = tcdm_req & {N_PORTS{rst_n}};

  // Address decode. The offset wraps, so addresses below the base look huge
  // and fail the range compare.
  always_comb begin
    w_off  = '0;
    w_inr  = '0;
    w_bank = '0;
    w_row  = '0;
    w_tgt  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_off[p]  = tcdm_add[p] - BASE_ADDR;
      w_inr[p]  = ({1'b0, w_off[p]} < MEM_BYTES);
      w_bank[p] = BSW'((w_off[p] >> 2) & 32'(N_BANKS - 1));
      w_row[p]  = RW'((w_off[p] >> (2 + LOG_NB)) & 32'(BANK_WORDS - 1));
      w_tgt[p]  = w_inr[p] ? TW'(w_bank[p]) : TW'(N_BANKS);
    end
  end

  // Round-robin pick per target. The first requester at or after ptr wins, wrapping.
  always_comb begin
    int             idx;
    logic [PW-1:0]  idx_p;
    logic           found;
    logic [PW-1:0]  win;
    idx       = 0;
    idx_p     = '0;
    found     = 1'b0;
    win       = '0;
    w_gnt     = '0;
    w_win     = '0;
    w_win_vld = '0;
    for (int b = 0; b <= N_BANKS; b++) begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < N_PORTS; k++) begin
        idx = int'(r_ptr[b]) + k;
        if (idx >= int'(N_PORTS)) idx = idx - int'(N_PORTS);
        idx_p = PW'(idx);
        if (!found && w_req[idx_p] && (w_tgt[idx_p] == TW'(b))) begin
          found = 1'b1;
          win   = idx_p;
        end
      end
      w_win_vld[b] = found;
      w_win[b]     = win;
      if (found) w_gnt[win] = 1'b1;
    end
  end

  assign tcdm_gnt = w_gnt;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [31:0]   r_mem [BANK_WORDS];
    logic [31:0]   r_q;
    logic [RW-1:0] w_row_sel;
    logic [3:0]    w_be_sel;
    logic [31:0]   w_wd_sel;
    logic          w_rd_sel;

    assign w_row_sel = w_row[w_win[b]];
    assign w_be_sel  = tcdm_be[w_win[b]];
    assign w_wd_sel  = tcdm_data[w_win[b]];
    assign w_rd_sel  = tcdm_wen[w_win[b]];

    // Single-ported bank: the winner either reads the row into r_q or byte-writes it.
    always_ff @(posedge clk) begin
      if (w_win_vld[b]) begin
        if (w_rd_sel) begin
          r_q <= r_mem[w_row_sel];
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (w_be_sel[i]) r_mem[w_row_sel][8*i +: 8] <= w_wd_sel[8*i +: 8];
          end
        end
      end
    end

    assign w_bank_q[b] = r_q;
  end

  // Arbiter pointers, response strobes, read-return routing and the sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_valid  <= '0;
      r_rd_hit <= '0;
      r_rsel   <= '0;
      r_oor    <= 1'b0;
    end else begin
      for (int b = 0; b <= N_BANKS; b++) begin
        if (w_win_vld[b]) begin
          r_ptr[b] <= (w_win[b] == PW'(N_PORTS - 1)) ? '0 : w_win[b] + PW'(1);
        end
      end
      r_valid  <= w_gnt;
      r_rd_hit <= w_gnt & tcdm_wen & w_inr;
      r_rsel   <= w_bank;
      if (|(w_gnt & ~w_inr)) r_oor <= 1'b1;
    end
  end

  // Only in-range read hits return bank data. Write acks, out-of-range reads
  // and idle cycles all return zero.
  always_comb begin
    tcdm_r_data = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      tcdm_r_data[p] = r_rd_hit[p] ? w_bank_q[r_rsel[p]] : 32'h0;
    end
  end

  assign tcdm_r_valid = r_valid;
  assign oor_err      = r_oor;

endmodule

// File: tb/tb_tcdm_responder.sv
// Bench for tcdm_responder: a flat word-array reference model with per-target
// rotating priority checks every cycle. Directed sequences pin literal values.
`timescale 1ns/1ps

module tb_tcdm_responder;

  localparam int NP = 3;
  localparam int NB = 4;
  localparam int BW = 1024;
  localparam int NW = NB * BW;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NP-1:0]       req, gnt, wen, r_valid;
  logic [NP-1:0][31:0] add, wdata, r_data;
  logic [NP-1:0][3:0]  be;
  logic                oor_err;

  tcdm_responder #(.N_PORTS(NP), .N_BANKS(NB), .BANK_WORDS(BW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .tcdm_req(req), .tcdm_gnt(gnt), .tcdm_add(add), .tcdm_wen(wen),
    .tcdm_be(be), .tcdm_data(wdata), .tcdm_r_data(r_data),
    .tcdm_r_valid(r_valid), .oor_err(oor_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]   m_mem   [NW];
  bit            m_known [NW];
  int            m_ptr   [NB+1];
  logic [NP-1:0] e_valid;
  logic [NP-1:0] e_dchk;
  logic [31:0]   e_rdata [NP];
  logic          e_oor;
  bit            m_live = 0;

  function automatic int tgt_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off < 32'(NW * 4)) return int'((off / 4) % NB);
    return NB;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off / 4);
  endfunction

  function automatic logic [NP-1:0] model_gnt();
    logic [NP-1:0] g;
    g = '0;
    if (rst_n !== 1'b1) return g;
    for (int t = 0; t <= NB; t++) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_ptr[t] + k) % NP;
        if (req[p] && tgt_of(add[p]) == t) begin
          g[p] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  always @(negedge clk) begin
    logic [NP-1:0] g;
    g = model_gnt();
    if (m_live) begin
      chk("gnt", 32'(gnt), 32'(g));
      chk("r_valid", 32'(r_valid), 32'(e_valid));
      for (int p = 0; p < NP; p++)
        if (e_dchk[p]) chk($sformatf("r_data%0d", p), r_data[p], e_rdata[p]);
      chk("oor_err", 32'(oor_err), 32'(e_oor));
    end
    if (rst_n !== 1'b1) begin
      e_valid = '0;
      e_dchk  = '1;
      e_oor   = 1'b0;
      for (int p = 0; p < NP; p++) e_rdata[p] = 32'h0;
      for (int t = 0; t <= NB; t++) m_ptr[t] = 0;
      m_live = 1;
    end else begin
      for (int p = 0; p < NP; p++) begin
        e_valid[p] = g[p];
        e_dchk[p]  = g[p];
        e_rdata[p] = 32'h0;
        if (g[p]) begin
          int t;
          t = tgt_of(add[p]);
          if (t == NB) e_oor = 1'b1;
          else if (wen[p]) begin
            e_rdata[p] = m_mem[word_of(add[p])];
            e_dchk[p]  = m_known[word_of(add[p])];
          end
          m_ptr[t] = (p + 1) % NP;
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (g[p] && !wen[p] && tgt_of(add[p]) != NB) begin
          int w;
          w = word_of(add[p]);
          for (int i = 0; i < 4; i++)
            if (be[p][i]) m_mem[w][8*i +: 8] = wdata[p][8*i +: 8];
          if (be[p] == 4'hF) m_known[w] = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int p, input logic rd, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    req[p]   = 1'b1;
    wen[p]   = rd;
    add[p]   = a;
    be[p]    = b;
    wdata[p] = d;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
    if (r == 16) return BASE - 32'd4;
    if (r == 17) return BASE + 32'h4000 + 32'(4 * $urandom_range(0, 15));
    if (r == 18) return $urandom;
    return BASE + 32'h3FFC;
  endfunction

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] last_g;
    req = '0; wen = '0; add = '0; be = '0; wdata = '0; rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // three ports on bank 0: strict rotation starting at p0
    drv(0, 1'b0, BASE + 32'h00, 4'hF, 32'hA0A0_0000);
    drv(1, 1'b0, BASE + 32'h10, 4'hF, 32'hB1B1_1111);
    drv(2, 1'b0, BASE + 32'h20, 4'hF, 32'hC2C2_2222);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt_c%0d", i), 32'(gnt), 32'(1 << (i % 3)));
      if (i > 0) chk($sformatf("rr_rvalid_c%0d", i), 32'(r_valid), 32'(1 << ((i - 1) % 3)));
      cyc();
    end
    req = '0;
    @(negedge clk); chk("rr_rvalid_last", 32'(r_valid), 32'h4);
    cyc();

    // three different banks in one cycle
    drv(0, 1'b1, BASE + 32'h0, 4'h0, 32'h0);
    drv(1, 1'b1, BASE + 32'h4, 4'h0, 32'h0);
    drv(2, 1'b1, BASE + 32'h8, 4'h0, 32'h0);
    @(negedge clk); chk("par_gnt", 32'(gnt), 32'h7);
    cyc(); req = '0;
    @(negedge clk); chk("par_rvalid", 32'(r_valid), 32'h7);
    chk("par_rdata0", r_data[0], 32'hA0A0_0000);
    cyc();

    // write then read back
    drv(0, 1'b0, BASE + 32'h10, 4'hF, 32'hCAFE_BABE);
    @(negedge clk); chk("wr_gnt", 32'(gnt), 32'h1);
    cyc(); drv(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    @(negedge clk); chk("rd_gnt", 32'(gnt), 32'h1); chk("wr_ack", 32'(r_valid), 32'h1);
    cyc(); req = '0;
    @(negedge clk); chk("rd_rvalid", 32'(r_valid), 32'h1);
    chk("rd_data", r_data[0], 32'hCAFE_BABE);
    cyc();

    // byte enables
    drv(1, 1'b0, BASE + 32'h30, 4'hF, 32'h1122_3344); cyc();
    drv(1, 1'b0, BASE + 32'h30, 4'h5, 32'hAABB_CCDD); cyc();
    drv(1, 1'b1, BASE + 32'h30, 4'h0, 32'h0); cyc(); req = '0;
    @(negedge clk); chk("be_data", r_data[1], 32'h11BB_33DD);
    cyc();

    // out-of-range accesses
    @(negedge clk); chk("oor_clear", 32'(oor_err), 32'h0);
    cyc();
    drv(1, 1'b1, BASE - 32'd4, 4'h0, 32'h0);
    @(negedge clk); chk("oor_rd_gnt", 32'(gnt), 32'h2);
    cyc(); req[1] = 1'b0; drv(2, 1'b0, BASE + 32'h4000, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk); chk("oor_rd_data", r_data[1], 32'h0);
    chk("oor_rise", 32'(oor_err), 32'h1); chk("oor_wr_gnt", 32'(gnt), 32'h4);
    cyc(); drv(2, 1'b1, BASE + 32'h4000, 4'h0, 32'h0);
    cyc(); req[2] = 1'b0; drv(0, 1'b1, BASE, 4'h0, 32'h0);
    @(negedge clk); chk("oor_rd2_data", r_data[2], 32'h0);
    chk("oor_rd2_valid", 32'(r_valid), 32'h4);
    cyc(); req = '0;
    @(negedge clk); chk("alias_word0", r_data[0], 32'hA0A0_0000);
    chk("oor_sticky", 32'(oor_err), 32'h1);
    cyc();

    // preload the words used by random traffic
    for (int w = 0; w < 17; w++) begin
      drv(0, 1'b0, BASE + 32'(((w == 16) ? 4095 : w) * 4), 4'hF, $urandom);
      cyc();
    end
    req = '0; cyc();

    // random traffic with occasional resets; losers hold their request
    last_g = '0;
    for (int c = 0; c < 2000; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      for (int p = 0; p < NP; p++) begin
        if (!(req[p] && !last_g[p])) begin
          req[p]   = ($urandom_range(0, 3) != 0);
          wen[p]   = 1'($urandom_range(0, 1));
          add[p]   = rand_addr();
          be[p]    = 4'($urandom);
          wdata[p] = $urandom;
        end
      end
      @(negedge clk); last_g = gnt;
      cyc();
    end
    rst_n = 1'b1; req = '0; cyc();

    // reset in the cycle after a grant
    drv(2, 1'b0, BASE + 32'h18, 4'hF, 32'h6666_6666); cyc(); req = '0; cyc();
    drv(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    drv(1, 1'b0, BASE + 32'h14, 4'hF, 32'h5555_AAAA);
    @(negedge clk); chk("pre_rst_gnt", 32'(gnt), 32'h3);
    cyc(); rst_n = 1'b0; drv(2, 1'b0, BASE + 32'h18, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk); chk("rst_gnt_gated", 32'(gnt), 32'h0);
    cyc(); rst_n = 1'b1;
    drv(0, 1'b1, BASE + 32'h04, 4'h0, 32'h0);
    drv(1, 1'b1, BASE + 32'h14, 4'h0, 32'h0);
    drv(2, 1'b1, BASE + 32'h18, 4'h0, 32'h0);
    @(negedge clk); chk("rst_rvalid_drop", 32'(r_valid), 32'h0);
    chk("rst_oor_clr", 32'(oor_err), 32'h0);
    chk("post_rst_gnt", 32'(gnt), 32'h5);
    cyc(); req[0] = 1'b0; req[2] = 1'b0;
    @(negedge clk); chk("post_rst_gnt2", 32'(gnt), 32'h2);
    chk("rst_wr_dropped", r_data[2], 32'h6666_6666);
    cyc(); req = '0;
    @(negedge clk); chk("rst_wr_completed", r_data[1], 32'h5555_AAAA);
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
